// File: rtl/cam_sliced_pkg.sv
// Package for the sliced binary CAM.
// Holds the default geometry, the derived constants, and the priority encoder
// that turns a hit vector into the lowest matching entry index.
package cam_sliced_pkg;

    localparam int unsigned CAM_DATA_WIDTH  = 128;
    localparam int unsigned CAM_ADDR_WIDTH  = 6;
    localparam int unsigned CAM_SLICE_WIDTH = 4;

    localparam int unsigned NUM_SLICES = CAM_DATA_WIDTH / CAM_SLICE_WIDTH;
    localparam int unsigned DEPTH      = 1 << CAM_ADDR_WIDTH;
    localparam int unsigned ROWS       = 1 << CAM_SLICE_WIDTH;

    // The encoder works on a fixed maximum width. Narrower hit vectors are
    // zero-extended by the caller, and the result is truncated back to the
    // caller's address width. This supports ADDR_WIDTH up to PE_IDX_WIDTH.
    localparam int unsigned PE_IDX_WIDTH = 8;
    localparam int unsigned PE_MAX_DEPTH = 1 << PE_IDX_WIDTH;

    // Lowest set bit to index; returns 0 when no bit is set.
    function automatic logic [PE_IDX_WIDTH-1:0] lowest_set_index(
        input logic [PE_MAX_DEPTH-1:0] vec
    );
        logic [PE_IDX_WIDTH-1:0] idx;
        logic                    found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < PE_MAX_DEPTH; i++) begin
            if (vec[i] && !found) begin
                idx   = PE_IDX_WIDTH'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/cam_sliced_slice.sv
// One slice of the sliced CAM: a ROWS x DEPTH one-hot bit matrix.
// Column a holds a single set bit in row r when entry a stores value r in this
// slice. A write clears the whole column and then sets the row for the new value.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset; clears the matrix
//   i_we         write strobe
//   i_wr_col     entry (column) being written
//   i_wr_row     slice value of the write data (row to set)
//   i_search_row slice value of the search key
//   o_row_vec    DEPTH-bit row selected by i_search_row (combinational)
module cam_sliced_slice
    import cam_sliced_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = CAM_ADDR_WIDTH,
    parameter int unsigned SLICE_WIDTH = CAM_SLICE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [ADDR_WIDTH-1:0]    i_wr_col,
    input  logic [SLICE_WIDTH-1:0]   i_wr_row,
    input  logic [SLICE_WIDTH-1:0]   i_search_row,
    output logic [(1<<ADDR_WIDTH)-1:0] o_row_vec
);

    localparam int unsigned N_ENTRIES = 1 << ADDR_WIDTH;
    localparam int unsigned N_ROWS    = 1 << SLICE_WIDTH;

    logic [N_ROWS-1:0][N_ENTRIES-1:0] r_matrix;

    // Clearing the column and setting the new row happen together: every row
    // of the written column is loaded with (row == write value).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_matrix <= '0;
        end else if (i_we) begin
            for (int unsigned r = 0; r < N_ROWS; r++) begin
                r_matrix[r][i_wr_col] <= (SLICE_WIDTH'(r) == i_wr_row);
            end
        end
    end

    assign o_row_vec = r_matrix[i_search_row];

endmodule

// File: rtl/cam_sliced.sv
// Sliced binary CAM, 2^ADDR_WIDTH entries of DATA_WIDTH bits.
// Every cycle din is searched against all valid entries; the registered result
// is a match flag and the lowest matching entry index. Entries are written by
// address, and a write fully replaces the old content of that entry.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset; clears contents and outputs
//   write_enable write din into entry write_addr at this edge
//   din          write data and search key (shared)
//   write_addr   entry index for writes
//   match        registered: at least one valid entry equals the search key
//   match_addr   registered: lowest matching entry index, 0 when match=0
module cam_sliced
    import cam_sliced_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = CAM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = CAM_ADDR_WIDTH,
    parameter int unsigned SLICE_WIDTH = CAM_SLICE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  match,
    output logic [ADDR_WIDTH-1:0] match_addr
);

    localparam int unsigned N_SLICES  = DATA_WIDTH / SLICE_WIDTH;
    localparam int unsigned N_ENTRIES = 1 << ADDR_WIDTH;

    logic [N_ENTRIES-1:0]                r_valid;
    logic [N_SLICES-1:0][N_ENTRIES-1:0]  w_slice_rows;
    logic [N_ENTRIES-1:0]                w_hit;
    logic                                r_match;
    logic [ADDR_WIDTH-1:0]               r_match_addr;

    for (genvar s = 0; s < N_SLICES; s++) begin : g_slice
        cam_sliced_slice #(
            .ADDR_WIDTH  (ADDR_WIDTH),
            .SLICE_WIDTH (SLICE_WIDTH)
        ) u_slice (
            .clk          (clk),
            .rst          (rst),
            .i_we         (write_enable),
            .i_wr_col     (write_addr),
            .i_wr_row     (din[s*SLICE_WIDTH +: SLICE_WIDTH]),
            .i_search_row (din[s*SLICE_WIDTH +: SLICE_WIDTH]),
            .o_row_vec    (w_slice_rows[s])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (write_enable) begin
            r_valid[write_addr] <= 1'b1;
        end
    end

    // An entry hits only when every slice selects a row with its column set.
    always_comb begin
        w_hit = r_valid;
        for (int unsigned s = 0; s < N_SLICES; s++) begin
            w_hit = w_hit & w_slice_rows[s];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_match      <= 1'b0;
            r_match_addr <= '0;
        end else begin
            r_match      <= |w_hit;
            r_match_addr <= ADDR_WIDTH'(lowest_set_index(PE_MAX_DEPTH'(w_hit)));
        end
    end

    assign match      = r_match;
    assign match_addr = r_match_addr;

endmodule

// File: tb/tb_cam_sliced.sv
module tb_cam_sliced;

    localparam int unsigned DW = 128;
    localparam int unsigned AW = 6;
    localparam int unsigned NE = 64;

    typedef struct packed {
        logic          m;
        logic [AW-1:0] a;
        int unsigned   id;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          write_enable;
    logic [DW-1:0] din;
    logic [AW-1:0] write_addr;
    logic          match;
    logic [AW-1:0] match_addr;

    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned n_issued;

    exp_t exp_q[$];

    // Reference model: plain array of stored words plus valid flags.
    logic [DW-1:0] ref_mem   [NE];
    logic          ref_valid [NE];

    logic [DW-1:0] pool [8];

    cam_sliced #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SLICE_WIDTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .din          (din),
        .write_addr   (write_addr),
        .match        (match),
        .match_addr   (match_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model_search(input logic [DW-1:0] key);
        exp_t e;
        e.m  = 1'b0;
        e.a  = '0;
        e.id = 0;
        for (int a = NE - 1; a >= 0; a--) begin
            if (ref_valid[a] && ref_mem[a] == key) begin
                e.m = 1'b1;
                e.a = AW'(a);
            end
        end
        return e;
    endfunction

    // One clock of stimulus: the search uses contents from before this write.
    task automatic drive(input logic we, input int unsigned addr, input logic [DW-1:0] d);
        exp_t e;
        @(negedge clk);
        write_enable = we;
        write_addr   = AW'(addr);
        din          = d;
        e            = model_search(d);
        e.id         = n_issued;
        n_issued++;
        exp_q.push_back(e);
        if (we) begin
            ref_mem[addr]   = d;
            ref_valid[addr] = 1'b1;
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        write_enable = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_match", 32'(match), 32'd0);
        check("async_rst_addr", 32'(match_addr), 32'd0);
        for (int a = 0; a < NE; a++) ref_valid[a] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: the DUT presents a result every cycle out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (match !== e.m || match_addr !== e.a) begin
                    n_bad++;
                    $display("FAIL search#%0d: actual match=%0b addr=%0d required match=%0b addr=%0d",
                             e.id, match, match_addr, e.m, e.a);
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] key_a;
        logic [DW-1:0] key_k;
        logic [DW-1:0] one;
        logic [DW-1:0] d;
        int unsigned   sel;

        n_cmp        = 0;
        n_bad        = 0;
        n_issued     = 0;
        rst          = 1'b0;
        write_enable = 1'b0;
        din          = '0;
        write_addr   = '0;
        for (int a = 0; a < NE; a++) begin
            ref_mem[a]   = '0;
            ref_valid[a] = 1'b0;
        end
        key_a = {32{4'ha}};
        key_k = 128'hdead_beef_0123_4567_89ab_cdef_fedc_ba98;
        one   = 128'h1;

        #13;
        check("reset_match", 32'(match), 32'd0);
        check("reset_addr", 32'(match_addr), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Cleared array: din=0 must not hit.
        drive(1'b0, 0, '0);
        check("model_empty", 32'(model_search('0).m), 32'd0);

        drive(1'b1, 0, key_a);
        drive(1'b1, 1, '0);
        drive(1'b0, 0, key_a);
        drive(1'b0, 0, '0);
        drive(1'b0, 0, 128'h1111_0000_0000_0000_0000_0000_0000_1111);

        drive(1'b1, 10, 128'h5);
        drive(1'b1, 3, 128'h5);
        drive(1'b0, 0, 128'h5);
        drive(1'b1, 3, 128'h6);
        drive(1'b0, 0, 128'h5);
        drive(1'b0, 0, 128'h6);

        drive(1'b1, 63, key_k);
        drive(1'b0, 0, key_k);

        mid_reset();
        drive(1'b0, 0, key_a);
        drive(1'b0, 0, key_k);
        drive(1'b0, 0, '0);

        // Randomized phase over a small key pool so hits and near-misses occur.
        for (int i = 0; i < 8; i++) pool[i] = {$urandom, $urandom, $urandom, $urandom};
        pool[1] = pool[0] ^ (one << 124);
        pool[2] = pool[0] ^ (one << 3);
        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8) d = pool[sel];
            else if (sel == 8) d = pool[$urandom_range(0, 7)] ^ (one << $urandom_range(0, 127));
            else d = {$urandom, $urandom, $urandom, $urandom};
            drive(($urandom_range(0, 2) == 0), $urandom_range(0, NE - 1), d);
            if (i == 900) mid_reset();
        end

        @(negedge clk);
        write_enable = 1'b0;
        @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cam_sliced.md
Name: cam_sliced

Overview:
- Binary content-addressable memory: 2^ADDR_WIDTH entries of DATA_WIDTH bits.
- Each cycle, din is searched against all valid entries. The result is a registered match flag and the lowest matching address.
- Entries are written by address.
- Storage is split into DATA_WIDTH/SLICE_WIDTH slices. Each slice holds a one-hot bit matrix of 2^SLICE_WIDTH rows × 2^ADDR_WIDTH columns. This sits in the password-lookup datapath.

Parameters:
- DATA_WIDTH, 128, search/write word width; must be a multiple of SLICE_WIDTH.
- ADDR_WIDTH, 6, log2 of entry count (64 entries).
- SLICE_WIDTH, 4, bits per slice; each slice matrix has 2^SLICE_WIDTH rows.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- write_enable  in  1  write din into entry write_addr at this edge.
- din  in  DATA_WIDTH  write data and search key (shared).
- write_addr  in  ADDR_WIDTH  entry index for writes.
- match  out  1  registered: at least one valid entry equals the searched key.
- match_addr  out  ADDR_WIDTH  registered: lowest matching entry index; 0 when match=0.

Behaviour:
- Reset (rst=0, async) clears:
  - all slice matrix bits;
  - all per-entry valid bits;
  - match=0 and match_addr=0.
  - Nothing matches after reset, including din=0.
- Slice s covers din[s*SLICE_WIDTH +: SLICE_WIDTH].
- Slice s row r, column a is set when entry a is valid and its slice-s value equals r.
- Write at a rising edge with write_enable=1:
  - Column write_addr is cleared in every row of every slice.
  - Row din-slice, column write_addr is set in each slice.
  - valid[write_addr] is set.
  - The old content of that address is fully replaced.
- Search is combinational over the current contents (the pre-edge state):
  - hit_vec[a] = valid[a] AND (bitwise AND over all slices of slice[s].row[din_s][a]).
- Registration at each rising edge:
  - match <= OR(hit_vec).
  - match_addr <= index of the lowest set bit of hit_vec, or 0 if there is none.
- Latency:
  - The result for din present before edge N appears after edge N (one cycle).
  - A write at edge N is first visible to the search registered at edge N+1.
  - Same-edge write plus search uses the contents from before the write.
- Duplicate contents at several addresses: the lowest address wins. This is a priority encoder from index 0 upward.
- Overwriting an address with new data makes the old value no longer match at that address.
- Search runs every cycle, including write cycles. There is no enable; outputs track din continuously with one-cycle delay.
- write_addr covers the full range 0..2^ADDR_WIDTH-1; no out-of-range case exists.
- A reset asserted mid-operation immediately clears outputs and contents. The first post-reset search result returns match=0.

Decomposition:
- Package cam_sliced_pkg:
  - derived constants NUM_SLICES = DATA_WIDTH/SLICE_WIDTH, DEPTH = 2^ADDR_WIDTH, ROWS = 2^SLICE_WIDTH;
  - a priority-encoder function (lowest set bit to index).
- One sub-module, cam_sliced_slice:
  - holds one ROWS×DEPTH bit matrix;
  - takes the write enable, write column, and write row;
  - outputs the DEPTH-bit row vector selected by the search nibble.
- The top generates NUM_SLICES instances and performs the valid AND, reduction and priority-encode register.

Test Plan:
- Reset, then search din=0 → match=0, match_addr=0; no false hit on the cleared array.
- Write 128'haaaa…aaaa to addr 0 and 128'h0 to addr 1, then search 128'haaaa…aaaa → one cycle later match=1, match_addr=0. Search 128'h0 → match=1, match_addr=1.
- Search 128'h1111_0000_…_0000_1111 → match=0, match_addr=0, because it differs in only some slices.
- Write 128'h5 to addr 10 and addr 3, then search 128'h5 → match_addr=3 (lowest wins). Overwrite addr 3 with 128'h6 and search 128'h5 → match_addr=10.
- Write key K to addr 63 while searching K on the same edge → no match that cycle; match=1, match_addr=63 on the following cycle.
- Assert rst low mid-stream after matches → outputs drop to 0 asynchronously; re-search of previous keys gives match=0.
